// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and helpers for the NPC integer register file.
//   DEF_XLEN / DEF_NREG / DEF_AW : default data width, register count, address width
//   REG_ZERO                     : index of the hardwired-zero register
//   rd_src_e / rd_src()          : read-port data source selection
package npc_pkg;

  localparam int unsigned DEF_XLEN = 64;
  localparam int unsigned DEF_NREG = 32;
  localparam int unsigned DEF_AW   = $clog2(DEF_NREG);
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } rd_src_e;

  // Register 0 takes priority over a bypass hit: a write to x0 never forwards.
  function automatic rd_src_e rd_src(input logic is_zero, input logic byp_hit);
    if (is_zero)      return SRC_ZERO;
    else if (byp_hit) return SRC_BYPASS;
    else              return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writebacks.
//   clock, reset         : clock, synchronous active-high reset
//   rAddr                : NRD packed read addresses
//   wen, wAddr           : writeback (clears busy)
//   issueEn, issueAddr   : issue (sets busy, visible next cycle)
//   rBusy                : per-read-port busy flag
//   anyBusy              : OR of all busy bits
module regfile_scoreboard
  import npc_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rAddr,
  input  logic              wen,
  input  logic [AW-1:0]     wAddr,
  input  logic              issueEn,
  input  logic [AW-1:0]     issueAddr,
  output logic [NRD-1:0]    rBusy,
  output logic              anyBusy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set beats clear: a same-cycle issue to the written register is a new producer.
  always_comb begin
    busy_d = busy_q;
    busy_d[REG_ZERO] = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (issueEn && (issueAddr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wen && (wAddr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback landing this cycle already satisfies the reader when bypassing.
  always_comb begin
    rBusy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (rAddr[k*AW +: AW] != AW'(REG_ZERO)) begin
        rBusy[k] = busy_q[rAddr[k*AW +: AW]] &
                   ~((BYPASS != 0) && wen && (wAddr == rAddr[k*AW +: AW]));
      end
    end
  end

  assign anyBusy = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with N read ports, optional
// write-to-read bypass, busy scoreboard and a debug read port.
//   clock, reset         : clock, synchronous active-high reset
//   rAddr / rData        : NRD packed read ports (combinational)
//   rBusy                : per-port pending-write flag
//   wen, wAddr, wData    : writeback
//   issueEn, issueAddr   : mark destination busy
//   dbgAddr / dbgData    : debug read of registered state (never bypassed)
//   anyBusy              : any register pending
module regfile_sb
  import npc_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rAddr,
  output logic [NRD*XLEN-1:0] rData,
  output logic [NRD-1:0]      rBusy,
  input  logic                wen,
  input  logic [AW-1:0]       wAddr,
  input  logic [XLEN-1:0]     wData,
  input  logic                issueEn,
  input  logic [AW-1:0]       issueAddr,
  input  logic [AW-1:0]       dbgAddr,
  output logic [XLEN-1:0]     dbgData,
  output logic                anyBusy
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wen && (wAddr != AW'(REG_ZERO))) begin
      regs_d[wAddr] = wData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rData = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      unique case (rd_src(rAddr[k*AW +: AW] == AW'(REG_ZERO),
                          (BYPASS != 0) && wen && (wAddr == rAddr[k*AW +: AW])))
        SRC_ZERO:   rData[k*XLEN +: XLEN] = '0;
        SRC_BYPASS: rData[k*XLEN +: XLEN] = wData;
        SRC_ARRAY:  rData[k*XLEN +: XLEN] = regs_q[rAddr[k*AW +: AW]];
        default:    rData[k*XLEN +: XLEN] = '0;
      endcase
    end
  end

  assign dbgData = (dbgAddr == AW'(REG_ZERO)) ? '0 : regs_q[dbgAddr];

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .rAddr     (rAddr),
    .wen       (wen),
    .wAddr     (wAddr),
    .issueEn   (issueEn),
    .issueAddr (issueAddr),
    .rBusy     (rBusy),
    .anyBusy   (anyBusy)
  );

endmodule
